tlu_handshake: RTL and testbench

TLU_HANDSHAKE -- requirements
Module: tlu_handshake

---
 rtl/tlu_handshake.sv | 121 ++++++++++++
 tb/tb_tlu_handshake.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlu_handshake.sv
// rtl/tlu_handshake.sv - TLU trigger handshake: busy, serial trigger-number readout, bookkeeping
module tlu_handshake #(
    parameter int ID_BITS     = 15,
    parameter int HALF_PER    = 4,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               trigger,
    input  logic               readout_done,
    output logic               busy,
    output logic               trigger_clock,
    output logic [ID_BITS-1:0] trig_id,
    output logic               trig_valid,
    output logic [31:0]        trig_count,
    output logic               timeout_err
);
    localparam int CYC_W = $clog2(2 * HALF_PER);
    localparam int BIT_W = $clog2(ID_BITS + 1);
    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(2 * HALF_PER - 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(HALF_PER);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ID_BITS - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACK, SHIFT, WAIT_DONE} state_t;

    state_t             state, state_next;
    logic               trg_m, trg_s;
    logic [CYC_W-1:0]   cyc, cyc_next;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [ACK_W-1:0]   ack_cnt, ack_cnt_next;
    logic [ID_BITS-1:0] shreg, shreg_next;
    logic               capture, timeout_hit, done_accept;

    always_comb begin
        state_next   = state;
        cyc_next     = cyc;
        bit_cnt_next = bit_cnt;
        ack_cnt_next = ack_cnt;
        shreg_next   = shreg;
        capture      = 1'b0;
        timeout_hit  = 1'b0;
        done_accept  = 1'b0;
        case (state)
            IDLE: begin
                ack_cnt_next = '0;
                if (trg_s && enable) state_next = ACK;
            end
            ACK: begin
                if (!trg_s) begin
                    state_next   = SHIFT;
                    cyc_next     = '0;
                    bit_cnt_next = '0;
                end else if (ack_cnt == ACK_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = WAIT_DONE;
                end else begin
                    ack_cnt_next = ack_cnt + 1'b1;
                end
            end
            SHIFT: begin
                // The TLU changes its data bit on our rising edge; sample at the very end of the low half.
                if (cyc == CYC_LAST) begin
                    shreg_next = {shreg[ID_BITS-2:0], trg_s};
                    cyc_next   = '0;
                    if (bit_cnt == BIT_LAST) begin
                        capture    = 1'b1;
                        state_next = WAIT_DONE;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end else begin
                    cyc_next = cyc + 1'b1;
                end
            end
            WAIT_DONE: begin
                // A done pulse coincident with trig_valid cannot belong to this trigger's readout.
                if (readout_done && !trig_valid) begin
                    done_accept = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trg_m         <= 1'b0;
            trg_s         <= 1'b0;
            state         <= IDLE;
            cyc           <= '0;
            bit_cnt       <= '0;
            ack_cnt       <= '0;
            shreg         <= '0;
            busy          <= 1'b0;
            trigger_clock <= 1'b0;
            trig_id       <= '0;
            trig_valid    <= 1'b0;
            trig_count    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            trg_m         <= trigger;
            trg_s         <= trg_m;
            state         <= state_next;
            cyc           <= cyc_next;
            bit_cnt       <= bit_cnt_next;
            ack_cnt       <= ack_cnt_next;
            shreg         <= shreg_next;
            // Looking at the current state keeps busy high for one cycle after IDLE is re-entered.
            busy          <= (state != IDLE) || (state_next != IDLE) || !enable;
            trigger_clock <= (state_next == SHIFT) && (cyc_next < CYC_HALF);
            trig_valid    <= capture;
            if (capture)     trig_id     <= shreg_next;
            if (done_accept) trig_count  <= trig_count + 32'd1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tlu_handshake.sv
// tb/tb_tlu_handshake.sv - self-checking bench for tlu_handshake with a behavioural TLU model
`timescale 1ns/1ps
module tb_tlu_handshake;
    localparam int ID_BITS     = 15;
    localparam int HALF_PER    = 4;
    localparam int ACK_TIMEOUT = 1000;

    logic               clk = 1'b0;
    logic               rst, enable, trigger, readout_done;
    logic               busy, trigger_clock, trig_valid, timeout_err;
    logic [ID_BITS-1:0] trig_id;
    logic [31:0]        trig_count;

    int total = 0;
    int bad   = 0;

    int   tcount = 0;
    int   tv_cnt, tc_rises, tc_high, first_rise, last_high;
    logic prev_tc = 1'b0;

    logic               tlu_active = 1'b0;
    logic [ID_BITS-1:0] tlu_id = '0;
    int                 tlu_idx = 0;
    int                 glitch_bit = -1;
    int                 glitch_ticks = 0;
    logic               held_bit = 1'b0;

    typedef struct {
        logic [ID_BITS-1:0] id;
        int                 drop_dly;
        int                 done_dly;
        logic [31:0]        exp_count;
    } vec_t;

    tlu_handshake #(.ID_BITS(ID_BITS), .HALF_PER(HALF_PER), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .readout_done(readout_done),
        .busy(busy), .trigger_clock(trigger_clock), .trig_id(trig_id), .trig_valid(trig_valid),
        .trig_count(trig_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: sample after the edge, then let the TLU model react to trigger_clock.
    task automatic tick();
        @(posedge clk);
        #1;
        tcount++;
        if (glitch_ticks > 0) begin
            glitch_ticks--;
            if (glitch_ticks == 0) trigger = held_bit;
        end
        if (trig_valid) tv_cnt++;
        if (trigger_clock) begin
            tc_high++;
            last_high = tcount;
        end
        if (trigger_clock && !prev_tc) begin
            tc_rises++;
            if (first_rise < 0) first_rise = tcount;
            if (tlu_active && tlu_idx >= 0) begin
                if (tlu_idx == glitch_bit) begin
                    held_bit     = tlu_id[tlu_idx];
                    trigger      = ~held_bit;
                    glitch_ticks = 2;
                end else begin
                    trigger = tlu_id[tlu_idx];
                end
                tlu_idx--;
            end
        end
        prev_tc = trigger_clock;
    endtask

    task automatic clear_mon();
        tv_cnt     = 0;
        tc_rises   = 0;
        tc_high    = 0;
        first_rise = -1;
        last_high  = -1;
    endtask

    task automatic finish_done(input logic [31:0] exp_count);
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
        check("busy_at_idle_entry", busy, 1);
        check("trig_count", trig_count, exp_count);
        tick();
        check("busy_after_idle", busy, !enable);
    endtask

    task automatic run_handshake(input logic [ID_BITS-1:0] id, input int drop_dly, input int done_dly,
                                 input int gbit, input int stray_at, input int en_drop_at,
                                 input bit early_done, input logic [31:0] exp_count);
        int n;
        int busy_low;
        clear_mon();
        tlu_id     = id;
        glitch_bit = gbit;
        trigger    = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        check("busy_on_trigger", busy, 1);
        repeat (drop_dly) tick();
        trigger    = 1'b0;
        tlu_idx    = ID_BITS - 1;
        tlu_active = 1'b1;
        n = 0;
        while (tv_cnt == 0 && n < 400) begin
            readout_done = (n == stray_at);
            if (n == en_drop_at) enable = 1'b0;
            tick();
            n++;
        end
        readout_done = 1'b0;
        tlu_active   = 1'b0;
        trigger      = 1'b0;
        glitch_bit   = -1;
        check("trig_id", trig_id, id);
        busy_low = 0;
        if (early_done) readout_done = 1'b1;
        for (int i = 0; i < done_dly; i++) begin
            tick();
            readout_done = 1'b0;
            if (!busy) busy_low++;
        end
        check("trig_valid_pulses", tv_cnt, 1);
        check("tclk_pulses", tc_rises, ID_BITS);
        check("tclk_high_cycles", tc_high, ID_BITS * HALF_PER);
        check("tclk_span", last_high - first_rise + 1, (2 * ID_BITS - 1) * HALF_PER);
        check("busy_low_in_wait", busy_low, 0);
        finish_done(exp_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               vecs[4];
        logic [ID_BITS-1:0] id, last_id;
        logic [31:0]        model_count;
        int                 n, busy_low;

        vecs[0] = '{15'h1A5B, 3, 50, 32'd1};
        vecs[1] = '{15'h7FFF, 3, 50, 32'd2};
        vecs[2] = '{15'h0000, 1, 10, 32'd3};
        vecs[3] = '{15'h5555, 7, 20, 32'd4};

        rst = 1'b1; enable = 1'b1; trigger = 1'b0; readout_done = 1'b0;
        clear_mon();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_tclk", trigger_clock, 0);
        check("rst_id", trig_id, 0);
        check("rst_valid", trig_valid, 0);
        check("rst_count", trig_count, 0);
        check("rst_timeout", timeout_err, 0);

        for (int i = 0; i < 4; i++)
            run_handshake(vecs[i].id, vecs[i].drop_dly, vecs[i].done_dly, -1, -1, -1, 1'b0, vecs[i].exp_count);
        model_count = 32'd4;
        last_id     = 15'h5555;

        model_count++;
        run_handshake(15'h2AAA, 3, 10, -1, -1, -1, 1'b1, model_count);
        model_count++;
        run_handshake(15'h1A5B, 4, 12, 14, 40, -1, 1'b0, model_count);
        model_count++;
        run_handshake(15'h3C3C, 2, 15, -1, -1, 30, 1'b0, model_count);
        last_id = 15'h3C3C;
        repeat (3) tick();
        check("busy_held_disabled", busy, 1);
        enable = 1'b1;
        tick();
        check("busy_reenabled", busy, 0);

        enable = 1'b0;
        tick();
        check("busy_when_disabled", busy, 1);
        clear_mon();
        busy_low = 0;
        trigger = 1'b1;
        repeat (10) begin tick(); if (!busy) busy_low++; end
        trigger = 1'b0;
        repeat (10) begin tick(); if (!busy) busy_low++; end
        check("dis_busy_low", busy_low, 0);
        check("dis_no_tclk", tc_rises, 0);
        check("dis_no_valid", tv_cnt, 0);
        check("dis_count", trig_count, model_count);
        enable = 1'b1;
        tick();
        check("dis_busy_release", busy, 0);

        clear_mon();
        trigger = 1'b1;
        for (int k = 1; k <= 1200; k++) begin
            tick();
            if (k == 990) check("timeout_early", timeout_err, 0);
        end
        check("timeout_err", timeout_err, 1);
        check("timeout_no_valid", tv_cnt, 0);
        check("timeout_no_tclk", tc_rises, 0);
        check("timeout_id", trig_id, last_id);
        trigger = 1'b0;
        repeat (5) tick();
        model_count++;
        finish_done(model_count);

        for (int r = 0; r < 6; r++) begin
            id = ID_BITS'($urandom_range(0, (1 << ID_BITS) - 1));
            model_count++;
            run_handshake(id, int'($urandom_range(1, 8)), int'($urandom_range(3, 60)), -1, -1, -1, 1'b0, model_count);
        end
        check("timeout_sticky", timeout_err, 1);

        clear_mon();
        tlu_id  = 15'h0AAA;
        trigger = 1'b1;
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        repeat (3) tick();
        trigger    = 1'b0;
        tlu_idx    = ID_BITS - 1;
        tlu_active = 1'b1;
        n = 0;
        while (tc_rises < 8 && n < 200) begin tick(); n++; end
        check("pre_rst_shifting", tc_rises, 8);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_tclk", trigger_clock, 0);
        check("arst_id", trig_id, 0);
        check("arst_valid", trig_valid, 0);
        check("arst_count", trig_count, 0);
        check("arst_timeout", timeout_err, 0);
        tlu_active = 1'b0;
        trigger    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_no_valid", tv_cnt, 0);
        model_count = 32'd1;
        run_handshake(15'h0001, 3, 20, -1, -1, -1, 1'b0, model_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
